// File: rtl/write_merge_buffer.sv
// Single-line write-combining buffer: merges byte-masked CPU writes to one line, then drains the full line.
// Optional read-forwarding of buffered words is compiled in with WRITE_MERGE_BUFFER_RD_FWD_EN.
module write_merge_buffer #(
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 12,
  localparam int unsigned BE_W      = WORD_W / 8,
  localparam int unsigned IDX_W     = $clog2(LINE_WORDS),
  localparam int unsigned LINE_W    = WORD_W * LINE_WORDS,
  localparam int unsigned LMASK_W   = LINE_W / 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_write,
  input  logic [ADDR_W-1:0]  cpu_line_addr,
  input  logic [IDX_W-1:0]   cpu_index,
  input  logic [BE_W-1:0]    cpu_wmask,
  input  logic [WORD_W-1:0]  cpu_wdata,
  output logic               cpu_resp,
  input  logic               flush,
  output logic               out_valid,
  output logic [ADDR_W-1:0]  out_line_addr,
  output logic [LINE_W-1:0]  out_data,
  output logic [LMASK_W-1:0] out_bmask,
  input  logic               out_ready,
  output logic               busy,
  input  logic [ADDR_W-1:0]  rd_line_addr,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_hit,
  output logic [WORD_W-1:0]  rd_data,
  output logic [BE_W-1:0]    rd_bmask
);

  typedef enum logic [1:0] {EMPTY, MERGE, DRAIN} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   line_addr;
  logic [LINE_W-1:0]   line_data;
  logic [LMASK_W-1:0]  line_mask;
  logic [LINE_W-1:0]   merged_data;
  logic [LMASK_W-1:0]  merged_mask;
  logic                addr_match;
  logic                wr_accept;

  assign addr_match = (cpu_line_addr == line_addr);
  assign wr_accept  = !rst && cpu_write &&
                      ((state == EMPTY) || ((state == MERGE) && addr_match));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a conflicting write or flush closes the line
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (cpu_write) state_nxt = MERGE;
      end
      MERGE: begin
        if ((cpu_write && !addr_match) || flush) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_ready) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Output decode; everything is forced quiet while rst is high
  always_comb begin
    cpu_resp      = 1'b0;
    out_valid     = 1'b0;
    busy          = 1'b0;
    out_line_addr = '0;
    out_data      = '0;
    out_bmask     = '0;
    if (!rst) begin
      cpu_resp      = wr_accept;
      out_valid     = (state == DRAIN);
      busy          = (state != EMPTY);
      out_line_addr = line_addr;
      out_data      = line_data;
      out_bmask     = line_mask;
    end
  end

  // Byte-lane merge of the incoming word into the current line image
  always_comb begin
    merged_data = line_data;
    merged_mask = line_mask;
    for (int i = 0; i < int'(LINE_WORDS); i++) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if ((IDX_W'(i) == cpu_index) && cpu_wmask[b]) begin
          merged_data[(i*BE_W+b)*8 +: 8] = cpu_wdata[b*8 +: 8];
          merged_mask[i*BE_W+b]          = 1'b1;
        end
      end
    end
  end

  // Line storage: cleared on reset and on a completed drain
  always_ff @(posedge clk) begin
    if (rst) begin
      line_addr <= '0;
      line_data <= '0;
      line_mask <= '0;
    end else if ((state == DRAIN) && out_ready) begin
      line_data <= '0;
      line_mask <= '0;
    end else if (wr_accept) begin
      line_addr <= cpu_line_addr;
      line_data <= merged_data;
      line_mask <= merged_mask;
    end
  end

`ifdef WRITE_MERGE_BUFFER_RD_FWD_EN
  logic [WORD_W-1:0] rd_word;
  logic [BE_W-1:0]   rd_wmask;
  logic              rd_match;

  always_comb begin
    rd_word  = '0;
    rd_wmask = '0;
    for (int i = 0; i < int'(LINE_WORDS); i++) begin
      if (IDX_W'(i) == rd_index) begin
        rd_word  = line_data[i*WORD_W +: WORD_W];
        rd_wmask = line_mask[i*BE_W +: BE_W];
      end
    end
  end

  assign rd_match = !rst && (state != EMPTY) && (rd_line_addr == line_addr) && (|rd_wmask);

  always_comb begin
    rd_hit   = 1'b0;
    rd_data  = '0;
    rd_bmask = '0;
    if (rd_match) begin
      rd_hit   = 1'b1;
      rd_data  = rd_word;
      rd_bmask = rd_wmask;
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd_line_addr, rd_index};
  assign rd_hit    = 1'b0;
  assign rd_data   = '0;
  assign rd_bmask  = '0;
`endif

endmodule
